mc_control_fsm: RTL and testbench

Parametrised multi-cycle MIPS control FSM that drives the datapath's mux selects, write enables and ALU operation each cycle. It gives the multi-cycle CPU a true synchronous reset, memory wait states, `bne`, a direct `jr` path and a sticky illegal-instruction trap. It sits beside the datapath, consuming `opcode`/`funct` from the instruction register.

---
 rtl/mc_cu_pkg.sv | 59 +++++
 rtl/mc_alu_decode.sv | 23 ++
 rtl/mc_control_fsm.sv | 184 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_cu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mc_cu_pkg;

    localparam int unsigned STATE_W    = 4;
    localparam int unsigned OP_W       = 6;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned ALU_CODE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_TRAP   = 4'd14
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FUNCT_JR = 6'd13;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'd1;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REGA   = 2'd3;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    localparam logic [1:0] ALUB_REGB = 2'd0;
    localparam logic [1:0] ALUB_FOUR = 2'd1;
    localparam logic [1:0] ALUB_IMM  = 2'd2;
    localparam logic [1:0] ALUB_IMM4 = 2'd3;

endpackage

// File: rtl/mc_alu_decode.sv
// R-type funct to ALU operation decode; flags funct codes beyond the JR slot.
module mc_alu_decode
    import mc_cu_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 4
) (
    input  logic [5:0]            funct_i,
    output logic [ALU_CTRL_W-1:0] alu_control_o,
    output logic                  illegal_o
);

    // funct 0..12 pass straight through as the ALU code; 13 is JR, above is illegal
    always_comb begin
        alu_control_o = ALU_CTRL_W'(ALU_ADD);
        illegal_o     = 1'b0;
        if (funct_i > FUNCT_JR) begin
            illegal_o = 1'b1;
        end else if (funct_i != FUNCT_JR) begin
            alu_control_o = ALU_CTRL_W'(funct_i[3:0]);
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM. Define MC_MEM_WAIT_EN to expose mem_ready
// and honour memory wait states; otherwise memory is treated as always ready.
module mc_control_fsm
    import mc_cu_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W  = 4,
    parameter int unsigned TRAP_STICKY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
`ifdef MC_MEM_WAIT_EN
    input  logic                  mem_ready,
`endif
    output logic                  mem_req,
    output logic                  iord,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic                  branch,
    output logic                  branch_ne,
    output logic [1:0]            pc_src,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [1:0]            reg_dst,
    output logic [1:0]            mem2reg,
    output logic                  trap,
    output logic [3:0]            state_o
);

    state_e                state_q;
    state_e                state_d;
    logic                  mem_rdy;
    logic [ALU_CTRL_W-1:0] dec_alu;
    logic                  dec_illegal;

`ifdef MC_MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    mc_alu_decode #(
        .ALU_CTRL_W(ALU_CTRL_W)
    ) u_alu_decode (
        .funct_i      (funct),
        .alu_control_o(dec_alu),
        .illegal_o    (dec_illegal)
    );

    // State register with synchronous reset into FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode; everything forced low while in reset
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        branch      = 1'b0;
        branch_ne   = 1'b0;
        pc_src      = PCSRC_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = ALUB_REGB;
        alu_control = ALU_CTRL_W'(ALU_ADD);
        reg_dst     = REGDST_RT;
        mem2reg     = M2R_ALU;
        trap        = 1'b0;
        state_o     = 4'd0;

        if (!rst) begin
            state_o = 4'(state_q);
            unique case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = ALUB_FOUR;
                    ir_write  = mem_rdy;
                    pc_write  = mem_rdy;
                    if (mem_rdy) state_d = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_b = ALUB_IMM4;
                    unique case (opcode)
                        OP_LW, OP_SW:    state_d = S_MEMADR;
                        OP_RTYPE:        state_d = (funct == FUNCT_JR) ? S_JR : S_EXEC;
                        OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                        OP_ADDI:         state_d = S_ADDIEX;
                        OP_J:            state_d = S_JUMP;
                        OP_JAL:          state_d = S_JAL;
                        default:         state_d = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                    state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    iord    = 1'b1;
                    mem_req = 1'b1;
                    if (mem_rdy) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    reg_write = 1'b1;
                    mem2reg   = M2R_MEM;
                    reg_dst   = REGDST_RT;
                    state_d   = S_FETCH;
                end
                S_MEMWR: begin
                    iord      = 1'b1;
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    if (mem_rdy) state_d = S_FETCH;
                end
                S_EXEC: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = ALUB_REGB;
                    alu_control = dec_alu;
                    state_d     = dec_illegal ? S_TRAP : S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = REGDST_RD;
                    mem2reg   = M2R_ALU;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_control = ALU_CTRL_W'(ALU_SUB);
                    pc_src      = PCSRC_ALUOUT;
                    branch      = (opcode == OP_BEQ);
                    branch_ne   = (opcode == OP_BNE);
                    state_d     = S_FETCH;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                    state_d   = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                    reg_dst   = REGDST_RT;
                    state_d   = S_FETCH;
                end
                S_JUMP: begin
                    pc_src   = PCSRC_JUMP;
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end
                S_JAL: begin
                    pc_src    = PCSRC_JUMP;
                    pc_write  = 1'b1;
                    reg_write = 1'b1;
                    reg_dst   = REGDST_RA;
                    mem2reg   = M2R_PC;
                    state_d   = S_FETCH;
                end
                S_JR: begin
                    pc_src   = PCSRC_REGA;
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end
                S_TRAP: begin
                    trap = 1'b1;
                    if (TRAP_STICKY == 0) state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: the driver queues one expected output
// vector per cycle, a negedge monitor pops and compares it.
module tb_mc_control_fsm;
    import mc_cu_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       branch;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic [1:0] reg_dst;
        logic [1:0] mem2reg;
        logic       trap;
        logic [3:0] state;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       mem_ready = 1'b1;
    logic       mem_req, iord, mem_write, ir_write, pc_write, reg_write;
    logic       branch, branch_ne, alu_src_a, trap;
    logic [1:0] pc_src, alu_src_b, reg_dst, mem2reg;
    logic [3:0] alu_control, state_o;
    obs_t       act;

    int total = 0;
    int bad   = 0;
    obs_t  exp_q[$];
    string name_q[$];

    mc_control_fsm #(
        .ALU_CTRL_W (4),
        .TRAP_STICKY(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
`ifdef MC_MEM_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .mem_req    (mem_req),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .branch     (branch),
        .branch_ne  (branch_ne),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_control(alu_control),
        .reg_dst    (reg_dst),
        .mem2reg    (mem2reg),
        .trap       (trap),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    assign act = {mem_req, iord, mem_write, ir_write, pc_write, reg_write, branch, branch_ne,
                  pc_src, alu_src_a, alu_src_b, alu_control, reg_dst, mem2reg, trap, state_o};

    function automatic obs_t mk(input state_e st,
                                input logic mreq = 1'b0, input logic io = 1'b0,
                                input logic mw = 1'b0, input logic irw = 1'b0,
                                input logic pcw = 1'b0, input logic rw = 1'b0,
                                input logic br = 1'b0, input logic bn = 1'b0,
                                input logic [1:0] pcs = 2'd0, input logic asa = 1'b0,
                                input logic [1:0] asb = 2'd0, input logic [3:0] alu = 4'd0,
                                input logic [1:0] rd = 2'd0, input logic [1:0] m2r = 2'd0,
                                input logic trp = 1'b0);
        obs_t o;
        o = '{mreq, io, mw, irw, pcw, rw, br, bn, pcs, asa, asb, alu, rd, m2r, trp, 4'(st)};
        return o;
    endfunction

    function automatic obs_t zero_out();
        obs_t o;
        o = '0;
        return o;
    endfunction

    function automatic obs_t e_fetch();
        return mk(.st(S_FETCH), .mreq(1'b1), .irw(1'b1), .pcw(1'b1), .asb(2'd1));
    endfunction

    function automatic obs_t e_decode();
        return mk(.st(S_DECODE), .asb(2'd3));
    endfunction

    // Drive one cycle of inputs and queue the output vector expected for it
    task automatic cyc(input string nm, input logic r, input logic [5:0] op,
                       input logic [5:0] fn, input logic mr, input obs_t e);
        @(posedge clk);
        #1;
        rst       = r;
        opcode    = op;
        funct     = fn;
        mem_ready = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare every queued expectation against the DUT mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s: got %h want %h (state got %0d want %0d)",
                         nm, act, e, act.state, e.state);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        cyc("reset0", 1'b1, 6'h00, 6'd0, 1'b1, zero_out());
        cyc("reset1", 1'b1, 6'h23, 6'd0, 1'b1, zero_out());

        // lw, no waits: 5 cycles
        cyc("lw_fetch",  1'b0, OP_LW, 6'd0, 1'b1, e_fetch());
        cyc("lw_decode", 1'b0, OP_LW, 6'd0, 1'b1, e_decode());
        cyc("lw_memadr", 1'b0, OP_LW, 6'd0, 1'b1, mk(.st(S_MEMADR), .asa(1'b1), .asb(2'd2)));
        cyc("lw_memrd",  1'b0, OP_LW, 6'd0, 1'b1, mk(.st(S_MEMRD), .mreq(1'b1), .io(1'b1)));
        cyc("lw_memwb",  1'b0, OP_LW, 6'd0, 1'b1, mk(.st(S_MEMWB), .rw(1'b1), .m2r(2'd1)));

        // sw: 4 cycles
        cyc("sw_fetch",  1'b0, OP_SW, 6'd0, 1'b1, e_fetch());
        cyc("sw_decode", 1'b0, OP_SW, 6'd0, 1'b1, e_decode());
        cyc("sw_memadr", 1'b0, OP_SW, 6'd0, 1'b1, mk(.st(S_MEMADR), .asa(1'b1), .asb(2'd2)));
        cyc("sw_memwr",  1'b0, OP_SW, 6'd0, 1'b1,
            mk(.st(S_MEMWR), .mreq(1'b1), .io(1'b1), .mw(1'b1)));

        // R-type funct 5: back in FETCH on cycle 5
        cyc("r5_fetch",  1'b0, OP_RTYPE, 6'd5, 1'b1, e_fetch());
        cyc("r5_decode", 1'b0, OP_RTYPE, 6'd5, 1'b1, e_decode());
        cyc("r5_exec",   1'b0, OP_RTYPE, 6'd5, 1'b1, mk(.st(S_EXEC), .asa(1'b1), .alu(4'd5)));
        cyc("r5_aluwb",  1'b0, OP_RTYPE, 6'd5, 1'b1, mk(.st(S_ALUWB), .rw(1'b1), .rd(2'd1)));

        // R-type funct 12 (highest legal ALU code)
        cyc("r12_fetch", 1'b0, OP_RTYPE, 6'd12, 1'b1, e_fetch());
        cyc("r12_decode",1'b0, OP_RTYPE, 6'd12, 1'b1, e_decode());
        cyc("r12_exec",  1'b0, OP_RTYPE, 6'd12, 1'b1, mk(.st(S_EXEC), .asa(1'b1), .alu(4'd12)));
        cyc("r12_aluwb", 1'b0, OP_RTYPE, 6'd12, 1'b1, mk(.st(S_ALUWB), .rw(1'b1), .rd(2'd1)));

        // addi: 4 cycles
        cyc("addi_fetch", 1'b0, OP_ADDI, 6'd0, 1'b1, e_fetch());
        cyc("addi_decode",1'b0, OP_ADDI, 6'd0, 1'b1, e_decode());
        cyc("addi_ex",    1'b0, OP_ADDI, 6'd0, 1'b1, mk(.st(S_ADDIEX), .asa(1'b1), .asb(2'd2)));
        cyc("addi_wb",    1'b0, OP_ADDI, 6'd0, 1'b1, mk(.st(S_ADDIWB), .rw(1'b1)));

        // beq and bne: 3 cycles each
        cyc("beq_fetch",  1'b0, OP_BEQ, 6'd0, 1'b1, e_fetch());
        cyc("beq_decode", 1'b0, OP_BEQ, 6'd0, 1'b1, e_decode());
        cyc("beq_branch", 1'b0, OP_BEQ, 6'd0, 1'b1,
            mk(.st(S_BRANCH), .br(1'b1), .pcs(2'd1), .asa(1'b1), .alu(4'd1)));
        cyc("bne_fetch",  1'b0, OP_BNE, 6'd0, 1'b1, e_fetch());
        cyc("bne_decode", 1'b0, OP_BNE, 6'd0, 1'b1, e_decode());
        cyc("bne_branch", 1'b0, OP_BNE, 6'd0, 1'b1,
            mk(.st(S_BRANCH), .bn(1'b1), .pcs(2'd1), .asa(1'b1), .alu(4'd1)));

        // j, jal, jr
        cyc("j_fetch",    1'b0, OP_J, 6'd0, 1'b1, e_fetch());
        cyc("j_decode",   1'b0, OP_J, 6'd0, 1'b1, e_decode());
        cyc("j_jump",     1'b0, OP_J, 6'd0, 1'b1, mk(.st(S_JUMP), .pcw(1'b1), .pcs(2'd2)));
        cyc("jal_fetch",  1'b0, OP_JAL, 6'd0, 1'b1, e_fetch());
        cyc("jal_decode", 1'b0, OP_JAL, 6'd0, 1'b1, e_decode());
        cyc("jal_jal",    1'b0, OP_JAL, 6'd0, 1'b1,
            mk(.st(S_JAL), .pcw(1'b1), .rw(1'b1), .pcs(2'd2), .rd(2'd2), .m2r(2'd2)));
        cyc("jr_fetch",   1'b0, OP_RTYPE, 6'd13, 1'b1, e_fetch());
        cyc("jr_decode",  1'b0, OP_RTYPE, 6'd13, 1'b1, e_decode());
        cyc("jr_jr",      1'b0, OP_RTYPE, 6'd13, 1'b1, mk(.st(S_JR), .pcw(1'b1), .pcs(2'd3)));

`ifdef MC_MEM_WAIT_EN
        // lw with two wait cycles in FETCH and in MEMRD: 9 cycles, one pc_write
        cyc("wlw_fwait0", 1'b0, OP_LW, 6'd0, 1'b0, mk(.st(S_FETCH), .mreq(1'b1), .asb(2'd1)));
        cyc("wlw_fwait1", 1'b0, OP_LW, 6'd0, 1'b0, mk(.st(S_FETCH), .mreq(1'b1), .asb(2'd1)));
        cyc("wlw_fetch",  1'b0, OP_LW, 6'd0, 1'b1, e_fetch());
        cyc("wlw_decode", 1'b0, OP_LW, 6'd0, 1'b1, e_decode());
        cyc("wlw_memadr", 1'b0, OP_LW, 6'd0, 1'b1, mk(.st(S_MEMADR), .asa(1'b1), .asb(2'd2)));
        cyc("wlw_rwait0", 1'b0, OP_LW, 6'd0, 1'b0, mk(.st(S_MEMRD), .mreq(1'b1), .io(1'b1)));
        cyc("wlw_rwait1", 1'b0, OP_LW, 6'd0, 1'b0, mk(.st(S_MEMRD), .mreq(1'b1), .io(1'b1)));
        cyc("wlw_memrd",  1'b0, OP_LW, 6'd0, 1'b1, mk(.st(S_MEMRD), .mreq(1'b1), .io(1'b1)));
        cyc("wlw_memwb",  1'b0, OP_LW, 6'd0, 1'b1, mk(.st(S_MEMWB), .rw(1'b1), .m2r(2'd1)));
`endif

        // reset in the middle of a store, with memory not ready
        cyc("rsw_fetch",  1'b0, OP_SW, 6'd0, 1'b1, e_fetch());
        cyc("rsw_decode", 1'b0, OP_SW, 6'd0, 1'b1, e_decode());
        cyc("rsw_memadr", 1'b0, OP_SW, 6'd0, 1'b1, mk(.st(S_MEMADR), .asa(1'b1), .asb(2'd2)));
        cyc("rsw_memwr",  1'b0, OP_SW, 6'd0, 1'b0,
            mk(.st(S_MEMWR), .mreq(1'b1), .io(1'b1), .mw(1'b1)));
        cyc("rsw_rst",    1'b1, OP_SW, 6'd0, 1'b0, zero_out());
        cyc("rsw_after",  1'b0, OP_SW, 6'd0, 1'b1, e_fetch());

        // illegal funct in EXEC traps
        cyc("r14_decode", 1'b0, OP_RTYPE, 6'd14, 1'b1, e_decode());
        cyc("r14_exec",   1'b0, OP_RTYPE, 6'd14, 1'b1, mk(.st(S_EXEC), .asa(1'b1)));
        cyc("r14_trap",   1'b0, OP_RTYPE, 6'd14, 1'b1, mk(.st(S_TRAP), .trp(1'b1)));
        cyc("r14_rst",    1'b1, OP_RTYPE, 6'd14, 1'b1, zero_out());

        // illegal opcode: sticky trap, then one reset cycle
        cyc("ill_fetch",  1'b0, 6'h3F, 6'd0, 1'b1, e_fetch());
        cyc("ill_decode", 1'b0, 6'h3F, 6'd0, 1'b1, e_decode());
        for (int i = 0; i < 12; i++) begin
            cyc("ill_trap", 1'b0, 6'h3F, 6'd0, 1'b1, mk(.st(S_TRAP), .trp(1'b1)));
        end
        cyc("ill_rst",    1'b1, 6'h3F, 6'd0, 1'b1, zero_out());
        cyc("ill_after",  1'b0, OP_J, 6'd0, 1'b1, e_fetch());
        cyc("ill_next",   1'b0, OP_J, 6'd0, 1'b1, e_decode());

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
